// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: in-order store queue between MEM1 and the D-cache write port.
// Stores are queued at the tail and drained from the head over a req/ack handshake.
// Younger loads are checked against queued stores every cycle.
// Build option SB_FORWARD_EN: when defined, matching loads receive merged forwarded
// bytes (youngest store wins per byte); when undefined, a matching load is stalled.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no valid entries, stores accepted
// BUSY  | one or more valid entries, stores accepted while not full
// DRAIN | stores blocked, entries keep draining until drain_req drops

module dcache_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wen,
  input  logic [31:0] st_wdata,
  output logic        cache_req,
  output logic [31:0] cache_addr,
  output logic [3:0]  cache_wen,
  output logic [31:0] cache_wdata,
  input  logic        cache_ack,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        ld_hit,
  output logic [3:0]  ld_bmask,
  output logic [31:0] ld_data,
  input  logic        drain_req,
  output logic        drain_done,
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t        state;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic [29:0]   ent_addr [DEPTH];
  logic [3:0]    ent_wen  [DEPTH];
  logic [31:0]   ent_data [DEPTH];

  logic          enq;
  logic          deq;
  logic          any_match;

  // Byte-offset bits are never stored or compared.
  logic          unused_low_bits;
  assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready   = (count != CW'(DEPTH)) && (state != DRAIN);
  assign cache_req  = (count != '0);
  assign sb_empty   = (count == '0);
  assign drain_done = (state == DRAIN) && (count == '0);

  // A zero-enable store completes the handshake but never occupies an entry.
  assign enq = st_valid && st_ready && (st_wen != 4'b0000);
  assign deq = cache_req && cache_ack;

  assign cache_addr  = {ent_addr[head], 2'b00};
  assign cache_wen   = ent_wen[head];
  assign cache_wdata = ent_data[head];

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Entry storage: written at the tail on enqueue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_wen[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else if (enq) begin
      ent_addr[tail] <= st_addr[31:2];
      ent_wen[tail]  <= st_wen;
      ent_data[tail] <= st_wdata;
    end
  end

  // Head/tail pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count_next;
    end
  end

  // Control FSM: IDLE/BUSY track occupancy, DRAIN is held while drain_req is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, BUSY: begin
          if (drain_req)               state <= DRAIN;
          else if (count_next == '0)   state <= IDLE;
          else                         state <= BUSY;
        end
        DRAIN: begin
          if (!drain_req) state <= (count_next == '0) ? IDLE : BUSY;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SB_FORWARD_EN
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
`endif

  // Load lookup: walk entries oldest to newest so younger bytes overwrite older ones.
  always_comb begin
    logic [PW-1:0] idx;
    any_match = 1'b0;
`ifdef SB_FORWARD_EN
    fwd_mask = '0;
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (ent_addr[idx] == ld_addr[31:2])) begin
        any_match = 1'b1;
`ifdef SB_FORWARD_EN
        fwd_mask = fwd_mask | ent_wen[idx];
        for (int b = 0; b < 4; b++) begin
          if (ent_wen[idx][b]) fwd_data[8*b +: 8] = ent_data[idx][8*b +: 8];
        end
`endif
      end
    end
  end

`ifdef SB_FORWARD_EN
  assign ld_stall = 1'b0;
  assign ld_hit   = ld_valid && any_match;
  assign ld_bmask = ld_valid ? fwd_mask : 4'b0000;
  assign ld_data  = ld_valid ? fwd_data : 32'h0;
`else
  assign ld_stall = ld_valid && any_match;
  assign ld_hit   = 1'b0;
  assign ld_bmask = 4'b0000;
  assign ld_data  = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Testbench for dcache_store_buffer: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_dcache_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_wen;
  logic [31:0] st_wdata;
  logic        cache_req;
  logic [31:0] cache_addr;
  logic [3:0]  cache_wen;
  logic [31:0] cache_wdata;
  logic        cache_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        ld_hit;
  logic [3:0]  ld_bmask;
  logic [31:0] ld_data;
  logic        drain_req;
  logic        drain_done;
  logic        sb_empty;

  dcache_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_wen(st_wen), .st_wdata(st_wdata),
    .cache_req(cache_req), .cache_addr(cache_addr), .cache_wen(cache_wen),
    .cache_wdata(cache_wdata), .cache_ack(cache_ack),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall), .ld_hit(ld_hit),
    .ld_bmask(ld_bmask), .ld_data(ld_data),
    .drain_req(drain_req), .drain_done(drain_done), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] a;
    logic [3:0]  w;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_drain;
  bit   last_acc;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit m_ready();
    return (q.size() != DEPTH) && !m_drain;
  endfunction

  task automatic model_load(input logic lv, input logic [31:0] la,
                            output logic any, output logic [3:0] bm, output logic [31:0] dt);
    any = 1'b0; bm = '0; dt = '0;
    foreach (q[i]) begin
      if (q[i].a == la[31:2]) begin
        any = 1'b1;
        bm  = bm | q[i].w;
        for (int b = 0; b < 4; b++)
          if (q[i].w[b]) dt[8*b +: 8] = q[i].d[8*b +: 8];
      end
    end
    if (!lv) begin any = 1'b0; bm = '0; dt = '0; end
  endtask

  task automatic check_outputs();
    logic        any;
    logic [3:0]  bm;
    logic [31:0] dt;
    chk("st_ready",   st_ready,   m_ready());
    chk("cache_req",  cache_req,  q.size() != 0);
    chk("sb_empty",   sb_empty,   q.size() == 0);
    chk("drain_done", drain_done, m_drain && (q.size() == 0));
    if (q.size() != 0) begin
      chk("cache_addr",  cache_addr,  {q[0].a, 2'b00});
      chk("cache_wen",   cache_wen,   q[0].w);
      chk("cache_wdata", cache_wdata, q[0].d);
    end
    model_load(ld_valid, ld_addr, any, bm, dt);
`ifdef SB_FORWARD_EN
    chk("ld_stall", ld_stall, 0);
    chk("ld_hit",   ld_hit,   any);
    chk("ld_bmask", ld_bmask, bm);
    chk("ld_data",  ld_data,  dt);
`else
    chk("ld_stall", ld_stall, any);
    chk("ld_hit",   ld_hit,   0);
    chk("ld_bmask", ld_bmask, 0);
    chk("ld_data",  ld_data,  0);
`endif
  endtask

  // One clock cycle: drive at negedge, check before the edge, advance the model at posedge.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [3:0] sw,
                      input logic [31:0] sd, input logic ack, input logic lv,
                      input logic [31:0] la, input logic dr);
    bit acc, dq;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_wen = sw; st_wdata = sd;
    cache_ack = ack; ld_valid = lv; ld_addr = la; drain_req = dr;
    #1;
    check_outputs();
    acc = sv && m_ready();
    dq  = (q.size() != 0) && ack;
    last_acc = acc;
    @(posedge clk);
    if (dq) void'(q.pop_front());
    if (acc && (sw != 4'b0000)) q.push_back('{a: sa[31:2], w: sw, d: sd});
    m_drain = dr;
  endtask

  task automatic idle(input logic ack, input logic dr);
    step(1'b0, 32'h0, 4'h0, 32'h0, ack, 1'b0, 32'h0, dr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    st_valid = 1'b0; cache_ack = 1'b0; ld_valid = 1'b0; drain_req = 1'b0;
    st_addr = '0; st_wen = '0; st_wdata = '0; ld_addr = '0;
    #1;
    q.delete();
    m_drain = 1'b0;
    chk("rst_cache_req",  cache_req,  0);
    chk("rst_sb_empty",   sb_empty,   1);
    chk("rst_st_ready",   st_ready,   1);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_ld_stall",   ld_stall,   0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int tries;
    bit dr_level;
    resetn = 1'b0;
    st_valid = 1'b0; cache_ack = 1'b0; ld_valid = 1'b0; drain_req = 1'b0;
    st_addr = '0; st_wen = '0; st_wdata = '0; ld_addr = '0;
    m_drain = 1'b0;
    do_reset();

    // Single store through an empty buffer with ack held high.
    step(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t1_accept", last_acc, 1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Fill with ack low; fifth store is refused until space frees up.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h100 + 32'(i*4), 4'hF, 32'hA000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h110, 4'hF, 32'hA004, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_full_refuse", last_acc, 0);
    tries = 0;
    do begin
      step(1'b1, 32'h110, 4'hF, 32'hA004, 1'b1, 1'b0, 32'h0, 1'b0);
      tries++;
    end while (!last_acc && tries < 20);
    chk("t2_fifth_accept", last_acc, 1);
    chk("t2_fifth_count", 32'(q.size()), 3);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b0);

    // Simultaneous enqueue and dequeue at count 2, crossing the pointer wrap.
    step(1'b1, 32'h300, 4'h1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h304, 4'h2, 32'h2200, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h308 + 32'(i*4), 4'hC, 32'h33330000 + 32'(i), 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_count_stays", 32'(q.size()), 2);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

    // Two overlapping stores to one word, then a load into that word.
    step(1'b1, 32'h2000, 4'h3, 32'h0000AABB, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h2000, 4'h2, 32'h0000CC00, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h2002, 1'b0);
`ifdef SB_FORWARD_EN
    chk("t4_hit",   ld_hit,   1);
    chk("t4_bmask", ld_bmask, 4'b0011);
    chk("t4_data",  ld_data,  32'h0000CCBB);
`else
    chk("t4_stall", ld_stall, 1);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h2002, 1'b0);
    chk("t4_after_drain_stall", ld_stall, 0);

    // Zero-enable store is accepted but not queued.
    step(1'b1, 32'h4000, 4'h0, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_zero_wen_accept", last_acc, 1);
    idle(1'b0, 1'b0);

    // Drain mode with three queued entries.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h500 + 32'(i*4), 4'hF, 32'h5000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 1'b1);
    step(1'b1, 32'h600, 4'hF, 32'h6, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_blocked", last_acc, 0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    chk("t6_drain_done", drain_done, 1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("t6_ready_back", st_ready, 1);

    // Reset with two entries pending and cache_req high.
    step(1'b1, 32'h700, 4'hF, 32'h7, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h704, 4'hF, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 1'b0);
    do_reset();
    idle(1'b0, 1'b0);

    // Random traffic over a small address window so loads often match.
    dr_level = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] sa, la;
      if ($urandom_range(0, 39) == 0) dr_level = ~dr_level;
      sa = 32'h2000 + {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      la = 32'h2000 + {28'h0, 2'($urandom_range(0, 4)), 2'($urandom_range(0, 3))};
      step(($urandom_range(0, 3) != 0), sa, 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), la, dr_level);
      if (c == 750) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
